// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the five-stage MIPS core.
// The decode stage uses the same names for its bus widths and enable encodings.
package regfile_pkg;

    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;
    localparam int REG_DATA_W   = 32;

    typedef logic [REG_DATA_W-1:0]   reg_bus_t;
    typedef logic [REG_NUM_LOG2-1:0] reg_addr_bus_t;

    localparam reg_bus_t      ZERO_WORD     = '0;
    localparam reg_addr_t_dummy_unused_guard = 0;
    localparam logic          WRITE_ENABLE  = 1'b1;
    localparam logic          WRITE_DISABLE = 1'b0;
    localparam logic          READ_ENABLE   = 1'b1;
    localparam logic          READ_DISABLE  = 1'b0;
    localparam reg_addr_bus_t NOP_REG_ADDR  = '0;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: write-back write port, two decode read ports, debug view.
// The master side is the pipeline (or a bench); the slave side is the register file.
interface regfile_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                re1;
    logic [ADDR_W-1:0]   raddr1;
    logic [DATA_W-1:0]   rdata1;
    logic                re2;
    logic [ADDR_W-1:0]   raddr2;
    logic [DATA_W-1:0]   rdata2;
    logic [ADDR_W-1:0]   dbg_addr;
    logic [DATA_W-1:0]   dbg_data;
    logic [NUM_REGS-1:0] written_o;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, written_o
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, written_o
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/enable/zero-register gating plus
// same-cycle forwarding of the write-back value over the stored entry.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rdata
);

    // Register 0 stays zero even when a write to it is being forwarded.
    always_comb begin
        rdata = DATA_W'(ZERO_WORD);
        if (rst_n && (re != READ_DISABLE) && (raddr != ADDR_W'(NOP_REG_ADDR))) begin
            if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
                rdata = wdata;
            end else begin
                rdata = stored;
            end
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit general-purpose register file with two forwarding read ports,
// one write port, a raw debug read and a written-since-reset bitmap.
module regfile
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REG_NUM,
    parameter int DATA_W   = REG_DATA_W
) (
    input  logic      clk,
    input  logic      rst_n,
    regfile_if.slave  bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] written;
    logic                wr_fire;

    assign wr_fire = (bus.we == WRITE_ENABLE) && (bus.waddr != ADDR_W'(NOP_REG_ADDR));

    // Entry 0 is never written, so it and written[0] hold zero from reset onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            written <= '0;
        end else if (wr_fire) begin
            regs[bus.waddr]    <= bus.wdata;
            written[bus.waddr] <= 1'b1;
        end
    end

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .rst_n  (rst_n),
        .re     (bus.re1),
        .raddr  (bus.raddr1),
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .stored (regs[bus.raddr1]),
        .rdata  (bus.rdata1)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .rst_n  (rst_n),
        .re     (bus.re2),
        .raddr  (bus.raddr2),
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .stored (regs[bus.raddr2]),
        .rdata  (bus.rdata2)
    );

    // Debug view is the raw array: no forwarding, so a write shows only after the edge.
    assign bus.dbg_data  = (!rst_n || (bus.dbg_addr == ADDR_W'(NOP_REG_ADDR)))
                           ? DATA_W'(ZERO_WORD) : regs[bus.dbg_addr];
    assign bus.written_o = written;

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes model expectations into a queue,
// a monitor on the falling edge pops them and compares against the DUT outputs.
module tb_regfile;
    import regfile_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] dbg_data;
        logic [31:0] written;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q [$];
    logic [31:0] model_regs [32];
    logic [31:0] model_written;

    always #5 clk = ~clk;

    regfile_if bus ();

    regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic rst, input logic en,
                                             input logic [4:0] addr, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (!rst || !en || addr == 5'd0) return ZERO_WORD;
        if (w && wa == addr) return wd;
        return model_regs[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_written = 32'h0;
    endtask

    // Drives one cycle of inputs, queues the expected outputs, then commits the write.
    task automatic applyStimulus(input string name, input logic r, input logic w,
                                 input logic [4:0] wa, input logic [31:0] wd,
                                 input logic e1, input logic [4:0] a1,
                                 input logic e2, input logic [4:0] a2,
                                 input logic [4:0] da);
        exp_t e;
        rst_n        = r;
        bus.we       = w;
        bus.waddr    = wa;
        bus.wdata    = wd;
        bus.re1      = e1;
        bus.raddr1   = a1;
        bus.re2      = e2;
        bus.raddr2   = a2;
        bus.dbg_addr = da;
        if (!r) model_clear();
        e.name     = name;
        e.rdata1   = ref_read(r, e1, a1, w, wa, wd);
        e.rdata2   = ref_read(r, e2, a2, w, wa, wd);
        e.dbg_data = (!r || da == 5'd0) ? 32'h0 : model_regs[da];
        e.written  = model_written;
        exp_q.push_back(e);
        @(posedge clk);
        if (r && w && wa != 5'd0) begin
            model_regs[wa]    = wd;
            model_written[wa] = 1'b1;
        end
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.name, ".rdata1"},   bus.rdata1,    e.rdata1);
                checkOutput({e.name, ".rdata2"},   bus.rdata2,    e.rdata2);
                checkOutput({e.name, ".dbg_data"}, bus.dbg_data,  e.dbg_data);
                checkOutput({e.name, ".written"},  bus.written_o, e.written);
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic        r, w, e1, e2;
        logic [4:0]  wa, a1, a2, da;
        logic [31:0] wd;

        model_clear();
        bus.we = WRITE_DISABLE; bus.waddr = 5'd0; bus.wdata = 32'h0;
        bus.re1 = READ_ENABLE;  bus.raddr1 = 5'd0;
        bus.re2 = READ_ENABLE;  bus.raddr2 = 5'd0;
        bus.dbg_addr = 5'd0;
        @(posedge clk);
        #1;

        repeat (3) applyStimulus("rst_hold", 0, 1, 5, 32'hDEADBEEF, 1, 5, 1, 5, 5);
        applyStimulus("rst_release", 1, 0, 5, 32'h0, 1, 5, 1, 5, 5);

        applyStimulus("wr3", 1, 1, 3, 32'h0000_1234, 0, 0, 0, 0, 3);
        applyStimulus("rd3", 1, 0, 0, 32'h0, 1, 3, 0, 0, 3);

        applyStimulus("wr7", 1, 1, 7, 32'h1, 0, 0, 0, 0, 7);
        applyStimulus("fwd7", 1, 1, 7, 32'hA5A5_A5A5, 1, 7, 1, 7, 7);
        applyStimulus("post7", 1, 0, 0, 32'h0, 1, 7, 1, 7, 7);

        applyStimulus("zero_wr", 1, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0);
        applyStimulus("zero_rd", 1, 0, 0, 32'h0, 1, 0, 1, 0, 0);

        applyStimulus("wr9", 1, 1, 9, 32'h55, 0, 0, 0, 0, 0);
        applyStimulus("gate_off", 1, 0, 0, 32'h0, 1, 3, 0, 9, 9);
        applyStimulus("gate_on", 1, 0, 0, 32'h0, 1, 3, 1, 9, 9);

        applyStimulus("wr4", 1, 1, 4, 32'h77, 1, 4, 1, 4, 4);
        applyStimulus("async_rst", 0, 0, 0, 32'h0, 1, 4, 1, 4, 4);
        applyStimulus("rd4_after", 1, 0, 0, 32'h0, 1, 4, 1, 4, 4);

        // Small address pool half the time so forwarding and port collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 63) != 0);
            w  = ($urandom_range(0, 9) < 7) ? WRITE_ENABLE : WRITE_DISABLE;
            e1 = ($urandom_range(0, 7) != 0) ? READ_ENABLE : READ_DISABLE;
            e2 = ($urandom_range(0, 7) != 0) ? READ_ENABLE : READ_DISABLE;
            if ($urandom_range(0, 1) == 0) begin
                wa = 5'($urandom_range(0, 7));
                a1 = 5'($urandom_range(0, 7));
                a2 = 5'($urandom_range(0, 7));
                da = 5'($urandom_range(0, 7));
            end else begin
                wa = 5'($urandom_range(0, 31));
                a1 = 5'($urandom_range(0, 31));
                a2 = 5'($urandom_range(0, 31));
                da = 5'($urandom_range(0, 31));
            end
            wd = $urandom();
            applyStimulus("rand", r, w, wa, wd, e1, a1, e2, a2, da);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
